// File: rtl/axi_rd_arb_pkg.sv
// Shared types for the two-requester AXI read-port arbiter.
package axi_rd_arb_pkg;

  typedef enum logic [1:0] {
    AIDLE = 2'd0,
    AADDR = 2'd1,
    ADATA = 2'd2
  } arb_state_t;

  localparam int NUM_REQ = 2;

  // One-hot grant to requester index (two-requester case).
  function automatic logic grant_idx(input logic [1:0] g);
    return g[1];
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter, purely combinational; shared with the write-channel arbiter.
module rr_arbiter2 (
  input  logic [1:0] request,
  input  logic       last_grant,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    case (request)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last_grant ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/axi_rd_arbiter.sv
// Burst-granular arbiter sharing one AXI4 read master between fetch (s0) and loads (s1).
// Optional ARB_PERF_CNT_EN adds saturating grant and stall counters.
module axi_rd_arbiter
  import axi_rd_arb_pkg::*;
#(
  parameter int AXI_ADDR_WIDTH = 64,
  parameter int AXI_DATA_WIDTH = 512
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      s0_arvalid,
  input  logic [AXI_ADDR_WIDTH-1:0] s0_araddr,
  input  logic [7:0]                s0_arlen,
  output logic                      s0_arready,
  output logic                      s0_rvalid,
  output logic [AXI_DATA_WIDTH-1:0] s0_rdata,
  output logic                      s0_rlast,
  input  logic                      s0_rready,
  output logic                      s0_busy,
  input  logic                      s1_arvalid,
  input  logic [AXI_ADDR_WIDTH-1:0] s1_araddr,
  input  logic [7:0]                s1_arlen,
  output logic                      s1_arready,
  output logic                      s1_rvalid,
  output logic [AXI_DATA_WIDTH-1:0] s1_rdata,
  output logic                      s1_rlast,
  input  logic                      s1_rready,
  output logic                      s1_busy,
  output logic                      m_axi_arvalid,
  output logic [AXI_ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [7:0]                m_axi_arlen,
  input  logic                      m_axi_arready,
  input  logic                      m_axi_rvalid,
  input  logic [AXI_DATA_WIDTH-1:0] m_axi_rdata,
  input  logic                      m_axi_rlast,
  output logic                      m_axi_rready,
`ifdef ARB_PERF_CNT_EN
  output logic [31:0]               s0_grant_cnt,
  output logic [31:0]               s1_grant_cnt,
  output logic [31:0]               stall_cnt,
`endif
  output logic                      len_err
);

  arb_state_t                                    state;
  logic                                          owner;
  logic                                          last_grant;
  logic [7:0]                                    beat;
  logic [NUM_REQ-1:0]                            busy;
  logic [NUM_REQ-1:0]                            req;
  logic [NUM_REQ-1:0]                            grant;
  logic [NUM_REQ-1:0][AXI_ADDR_WIDTH-1:0]        req_addr;
  logic [NUM_REQ-1:0][7:0]                       req_len;
  logic [NUM_REQ-1:0]                            req_rready;
  logic                                          idle;
  logic                                          in_data;
  logic                                          grant_en;
  logic                                          r_hs;
  logic                                          win;

  assign req        = {s1_arvalid, s0_arvalid};
  assign req_addr   = {s1_araddr, s0_araddr};
  assign req_len    = {s1_arlen, s0_arlen};
  assign req_rready = {s1_rready, s0_rready};

  rr_arbiter2 u_rr (
    .request    (req),
    .last_grant (last_grant),
    .grant      (grant)
  );

  assign idle     = (state == AIDLE);
  assign in_data  = (state == ADATA);
  assign win      = grant_idx(grant);
  // Gating with reset keeps arready quiet while a reset is being applied.
  assign grant_en = idle & ~reset & (|req);

  assign s0_arready = grant_en & grant[0];
  assign s1_arready = grant_en & grant[1];

  assign m_axi_rready = in_data & req_rready[owner];
  assign r_hs         = m_axi_rvalid & m_axi_rready;

  assign s0_rvalid = in_data & ~owner & m_axi_rvalid;
  assign s1_rvalid = in_data &  owner & m_axi_rvalid;
  assign s0_rlast  = in_data & ~owner & m_axi_rlast;
  assign s1_rlast  = in_data &  owner & m_axi_rlast;
  assign s0_rdata  = m_axi_rdata;
  assign s1_rdata  = m_axi_rdata;

  assign s0_busy = busy[0];
  assign s1_busy = busy[1];

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= AIDLE;
      owner         <= 1'b0;
      last_grant    <= 1'b0;
      beat          <= 8'd0;
      busy          <= '0;
      m_axi_arvalid <= 1'b0;
      m_axi_araddr  <= '0;
      m_axi_arlen   <= 8'd0;
      len_err       <= 1'b0;
    end else begin
      case (state)
        AIDLE: if (|req) begin
          state         <= AADDR;
          owner         <= win;
          last_grant    <= win;
          busy          <= grant;
          m_axi_arvalid <= 1'b1;
          m_axi_araddr  <= req_addr[win];
          m_axi_arlen   <= req_len[win];
        end
        AADDR: if (m_axi_arready) begin
          state         <= ADATA;
          m_axi_arvalid <= 1'b0;
          beat          <= 8'd0;
        end
        ADATA: if (r_hs) begin
          beat <= beat + 8'd1;
          // Early rlast and missing rlast both flag; the burst still ends on rlast.
          if (m_axi_rlast != (beat == m_axi_arlen)) len_err <= 1'b1;
          if (m_axi_rlast) begin
            state <= AIDLE;
            busy  <= '0;
          end
        end
        default: begin
          state <= AIDLE;
          busy  <= '0;
        end
      endcase
    end
  end

`ifdef ARB_PERF_CNT_EN
  logic stall_hit;
  assign stall_hit = ((|req) & ~idle) | (idle & (&req));

  always_ff @(posedge clk) begin
    if (reset) begin
      s0_grant_cnt <= '0;
      s1_grant_cnt <= '0;
      stall_cnt    <= '0;
    end else begin
      if (s0_arready && s0_grant_cnt != '1) s0_grant_cnt <= s0_grant_cnt + 32'd1;
      if (s1_arready && s1_grant_cnt != '1) s1_grant_cnt <= s1_grant_cnt + 32'd1;
      if (stall_hit && stall_cnt != '1)     stall_cnt    <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule
